// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus controller: FSM state encoding
// and the default start of the I/O window.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDRAIN = 2'd1,
        RDWAIT = 2'd2
    } bus_state_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: synchronous first-word-fall-through FIFO holding
// packed {addr, data} entries; pointers wrap modulo DEPTH.
module wbuf_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side stage behind the cpu core: posts writes into a buffer,
// serves reads after the drain and decodes a single-cycle I/O window.
//
//  state  | meaning
//  IDLE   | no memory access in flight
//  WDRAIN | head buffered write on the bus, waiting for mem_ack
//  RDWAIT | memory read on the bus, waiting for mem_ack
module mem_bus_ctrl
    import bus_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                WBUF_DEPTH = 4,
    parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              io_sel,
    output logic              io_we,
    output logic [7:0]        io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata
);
    bus_state_t                state;
    logic [DATA_W-1:0]         rdata_q;
    logic [ADDR_W+DATA_W-1:0]  head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      is_io;
    logic                      wr_post;
    logic                      io_go;
    logic                      rd_issue;
    logic                      rd_done;
    logic                      pop;

    assign is_io    = (cpu_addr >= IO_BASE);
    assign wr_post  = cpu_req & ~cpu_rw & ~is_io & ~fifo_full;
    assign io_go    = cpu_req & is_io & fifo_empty & (state == IDLE);
    assign rd_issue = cpu_req & cpu_rw & ~is_io & fifo_empty & (state == IDLE);
    assign rd_done  = (state == RDWAIT) & mem_ack;
    assign pop      = (state == WDRAIN) & mem_ack;

    wbuf_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (wr_post),
        .pop   (pop),
        .din   ({cpu_addr, cpu_wdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Combinational handshake outputs are gated by reset so that every
    // output reads zero while reset is held, whatever the core drives.
    assign cpu_ready = reset & (wr_post | io_go | rd_done);
    assign io_sel    = reset & io_go;
    assign io_we     = io_sel & ~cpu_rw;
    assign io_addr   = io_sel ? cpu_addr[7:0] : 8'h00;
    assign io_wdata  = io_sel ? cpu_wdata : '0;
    assign cpu_rdata = (io_sel & cpu_rw) ? io_rdata :
                       rd_done           ? mem_rdata : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (io_sel & cpu_rw) rdata_q <= io_rdata;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mem_req                <= 1'b1;
                        mem_we                 <= 1'b1;
                        {mem_addr, mem_wdata}  <= head;
                        state                  <= WDRAIN;
                    end else if (rd_issue) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= cpu_addr;
                        state    <= RDWAIT;
                    end
                end
                WDRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RDWAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= mem_rdata;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The core must hold its request until it is accepted.
    req_held: assert property (@(posedge clk) disable iff (!reset)
                               cpu_req && !cpu_ready |=> cpu_req);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a latency-programmable memory responder.
module tb_mem_bus_ctrl;
    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_rw;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        io_sel;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    logic        ack_resp;
    logic        ack_stray;
    logic        ack_en;
    int          lat;
    int          errors;
    int          checks;

    logic [31:0] tbmem [logic [31:0]];
    logic        log_we   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    assign mem_ack = ack_resp | ack_stray;

    mem_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack arrives lat cycles after mem_req is first seen.
    initial begin
        int cnt;
        cnt       = 0;
        ack_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            ack_resp = 1'b0;
            if (mem_req && ack_en) begin
                cnt++;
                if (cnt == lat + 1) begin
                    cnt = 0;
                    ack_resp = 1'b1;
                    log_we.push_back(mem_we);
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_wdata);
                    if (mem_we) tbmem[mem_addr] = mem_wdata;
                    else mem_rdata = tbmem.exists(mem_addr) ? tbmem[mem_addr] : 32'hFFFF_FFFF;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         output int cyc, output logic [31:0] rdata);
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cyc       = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) break;
            if (cyc >= 40) begin
                chk("ready_timeout", cpu_ready, 1'b1);
                break;
            end
            cyc++;
            tick();
        end
        rdata = cpu_rdata;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (log_addr.size() >= n && !mem_req) break;
        end
        chk("drain_count", log_addr.size(), n);
        tick();
    endtask

    initial begin
        int          cyc;
        int          acc;
        logic [31:0] rd;

        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_rw    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        io_rdata  = '0;
        ack_stray = 1'b0;
        ack_en    = 1'b0;
        lat       = 2;
        tbmem[32'h10] = 32'h1111_1111;
        tbmem[32'h20] = 32'hCAFE_0020;

        #12;
        chk("reset_outs", 32'(|{cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata,
                                io_sel, io_we, io_addr, io_wdata}), 0);
        tick();
        reset = 1'b1;
        tick();

        // 1: three posted writes, memory acks 2 cycles after mem_req
        ack_en = 1'b1;
        lat    = 2;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), cyc, rd);
            chk("post_latency", cyc, 0);
        end
        wait_drain(3);
        for (int i = 0; i < 3; i++) begin
            chk("post_we",   32'(log_we[i]), 1);
            chk("post_addr", log_addr[i], 32'h100 + 32'(4*i));
            chk("post_data", log_data[i], 32'hA0 + 32'(i));
        end

        // 2: fill the buffer with memory stalled, fifth write must wait
        ack_en = 1'b0;
        lat    = 1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 32'h200 + 32'(4*i), 32'hB0 + 32'(i), cyc, rd);
            chk("fill_latency", cyc, 0);
        end
        cpu_req   = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 32'h210;
        cpu_wdata = 32'hB4;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc += int'(cpu_ready);
            tick();
        end
        chk("full_stall", acc, 0);
        chk("full_memreq", mem_req, 1'b1);
        @(negedge clk);
        ack_en = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1 || cyc > 20) break;
            cyc++;
        end
        chk("full_release", cpu_ready, 1'b1);
        chk("full_after_one_ack", log_addr.size(), 4);
        tick();
        cpu_req = 1'b0;
        wait_drain(8);
        for (int i = 0; i < 5; i++) begin
            chk("full_order_addr", log_addr[3+i], 32'h200 + 32'(4*i));
            chk("full_order_data", log_data[3+i], 32'hB0 + 32'(i));
        end

        // 3: read after write to the same address
        lat = 2;
        issue(1'b0, 32'h10, 32'hDEAD_BEEF, cyc, rd);
        chk("raw_post", cyc, 0);
        issue(1'b1, 32'h10, 32'h0, cyc, rd);
        chk("raw_latency", cyc, 7);
        chk("raw_rdata", rd, 32'hDEAD_BEEF);
        chk("raw_order_we0", 32'(log_we[8]), 1);
        chk("raw_order_we1", 32'(log_we[9]), 0);
        chk("raw_read_addr", log_addr[9], 32'h10);

        // 4: I/O write and read
        cpu_req   = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 32'hFFFF_0004;
        cpu_wdata = 32'h55;
        @(negedge clk);
        chk("io_w_sel",   io_sel, 1'b1);
        chk("io_w_we",    io_we, 1'b1);
        chk("io_w_addr",  io_addr, 8'h04);
        chk("io_w_data",  io_wdata, 32'h55);
        chk("io_w_ready", cpu_ready, 1'b1);
        chk("io_w_nomem", mem_req, 1'b0);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("io_sel_pulse", io_sel, 1'b0);
        tick();
        cpu_req   = 1'b1;
        cpu_rw    = 1'b1;
        cpu_addr  = 32'hFFFF_0008;
        io_rdata  = 32'h1234;
        @(negedge clk);
        chk("io_r_ready", cpu_ready, 1'b1);
        chk("io_r_rdata", cpu_rdata, 32'h1234);
        chk("io_r_we",    io_we, 1'b0);
        chk("io_r_addr",  io_addr, 8'h08);
        tick();
        cpu_req  = 1'b0;
        io_rdata = 32'h0;
        @(negedge clk);
        chk("io_r_hold", cpu_rdata, 32'h1234);
        tick();
        // I/O behind a buffered write waits for the drain
        issue(1'b0, 32'h300, 32'hD0, cyc, rd);
        issue(1'b0, 32'hFFFF_0010, 32'h66, cyc, rd);
        chk("io_order_latency", cyc, 4);
        chk("io_order_drained", log_addr.size(), 11);

        // 5: minimum read latency
        lat = 1;
        issue(1'b1, 32'h20, 32'h0, cyc, rd);
        chk("rd_latency", cyc, 2);
        chk("rd_data", rd, 32'hCAFE_0020);
        @(negedge clk);
        chk("rd_hold", cpu_rdata, 32'hCAFE_0020);
        tick();
        // stray ack while idle is ignored
        ack_stray = 1'b1;
        @(negedge clk);
        chk("stray_ready", cpu_ready, 1'b0);
        chk("stray_rdata", cpu_rdata, 32'hCAFE_0020);
        tick();
        ack_stray = 1'b0;
        @(negedge clk);
        chk("stray_memreq", mem_req, 1'b0);
        tick();
        issue(1'b1, 32'h10, 32'h0, cyc, rd);
        chk("stray_after_lat", cyc, 2);
        chk("stray_after_data", rd, 32'hDEAD_BEEF);

        // 6: reset with two writes buffered and mem_req high
        ack_en = 1'b0;
        issue(1'b0, 32'h400, 32'hC0, cyc, rd);
        issue(1'b0, 32'h404, 32'hC1, cyc, rd);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("rst_pre_memreq", mem_req, 1'b1);
        cpu_req  = 1'b1;
        cpu_rw   = 1'b1;
        cpu_addr = 32'hFFFF_000C;
        io_rdata = 32'h77;
        #1;
        reset = 1'b0;
        #1;
        chk("rst_memreq", mem_req, 1'b0);
        chk("rst_outs", 32'(|{cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata,
                              io_sel, io_we, io_addr, io_wdata}), 0);
        tick();
        cpu_req  = 1'b0;
        io_rdata = 32'h0;
        tick();
        reset  = 1'b1;
        ack_en = 1'b1;
        lat    = 1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc += int'(mem_req);
            tick();
        end
        chk("rst_no_memreq", acc, 0);
        chk("rst_no_access", log_addr.size(), 13);
        issue(1'b1, 32'h404, 32'h0, cyc, rd);
        chk("rst_rd_latency", cyc, 2);
        chk("rst_rd_data", rd, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
